// File: rtl/sdram_arbiter_pkg.sv
// Shared types and encodings for the two-port SDRAM arbiter.
// Imported by the arbiter, its bus interface and the testbench.
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam logic [1:0] DW_BYTE = 2'b00;
  localparam logic [1:0] DW_HALF = 2'b01;
  localparam logic [1:0] DW_WORD = 2'b10;

  // One request's worth of controller fields, latched at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        dwidth;
  } mem_req_t;

  // Port 0 has fixed priority unless port 1 has waited long enough.
  function automatic logic pick_port(input logic r0, input logic r1, input logic starved);
    return (r1 && (!r0 || starved)) ? PORT_AUX : PORT_CPU;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SDRAM controller.
// slave = arbiter view; master = the environment around it (requesters + controller).
interface sdram_arbiter_if;
  import sdram_arb_pkg::*;

  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_write;
  logic [DATA_W-1:0] p0_wdata;
  logic [1:0]        p0_dwidth;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_write;
  logic [DATA_W-1:0] p1_wdata;
  logic [1:0]        p1_dwidth;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              sdram_enable;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_write;
  logic [DATA_W-1:0] sdram_wdata;
  logic [1:0]        sdram_dwidth;
  logic [DATA_W-1:0] sdram_rdata;
  logic              sdram_ready;

  modport slave (
    input  p0_req, p0_addr, p0_write, p0_wdata, p0_dwidth,
    input  p1_req, p1_addr, p1_write, p1_wdata, p1_dwidth,
    input  sdram_rdata, sdram_ready,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output sdram_enable, sdram_addr, sdram_write, sdram_wdata, sdram_dwidth
  );

  modport master (
    output p0_req, p0_addr, p0_write, p0_wdata, p0_dwidth,
    output p1_req, p1_addr, p1_write, p1_wdata, p1_dwidth,
    output sdram_rdata, sdram_ready,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  sdram_enable, sdram_addr, sdram_write, sdram_wdata, sdram_dwidth
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the CPU (port 0) and an auxiliary master (port 1).
// Fixed port-0 priority, bounded by a starvation counter that eventually forces a port-1 grant.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  sdram_arbiter_if.slave  bus,
  output logic            busy,
  output logic            owner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state, state_nxt;
  mem_req_t          lat_q, lat_d;
  logic              enable_q, enable_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_d, owner_d;
  logic [3:0]        starve_cnt, starve_cnt_nxt;

  logic     any_req, starved, winner;
  mem_req_t p0_fields, p1_fields;

  assign any_req   = bus.p0_req | bus.p1_req;
  assign starved   = (starve_cnt == LIMIT);
  assign winner    = pick_port(bus.p0_req, bus.p1_req, starved);
  assign p0_fields = {bus.p0_addr, bus.p0_write, bus.p0_wdata, bus.p0_dwidth};
  assign p1_fields = {bus.p1_addr, bus.p1_write, bus.p1_wdata, bus.p1_dwidth};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a missing branch
    // would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (bus.sdram_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; sdram_ready is only honoured in BUSY.
  always_comb begin
    lat_d          = lat_q;
    enable_d       = 1'b0;
    ack0_d         = 1'b0;
    ack1_d         = 1'b0;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    owner_d        = owner;
    busy_d         = (state_nxt != IDLE);
    starve_cnt_nxt = starve_cnt;

    case (state)
      IDLE: begin
        if (any_req) begin
          lat_d    = (winner == PORT_AUX) ? p1_fields : p0_fields;
          owner_d  = winner;
          enable_d = 1'b1;
          if (winner == PORT_AUX)
            starve_cnt_nxt = 4'd0;
          else if (bus.p1_req && starve_cnt < LIMIT)
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
      end
      BUSY: begin
        if (bus.sdram_ready) begin
          if (owner == PORT_AUX) begin
            ack1_d   = 1'b1;
            rdata1_d = bus.sdram_rdata;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = bus.sdram_rdata;
          end
        end else begin
          enable_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: these are plain registers, not a memory array, so all of them take a
  // reset value; rdata included, since requesters may look at it before any ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q      <= '0;
      enable_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      owner      <= PORT_CPU;
      busy       <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      lat_q      <= lat_d;
      enable_q   <= enable_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      owner      <= owner_d;
      busy       <= busy_d;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  assign bus.sdram_enable = enable_q;
  assign bus.sdram_addr   = lat_q.addr;
  assign bus.sdram_write  = lat_q.write;
  assign bus.sdram_wdata  = lat_q.wdata;
  assign bus.sdram_dwidth = lat_q.dwidth;
  assign bus.p0_ack       = ack0_q;
  assign bus.p1_ack       = ack1_q;
  assign bus.p0_rdata     = rdata0_q;
  assign bus.p1_rdata     = rdata1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table of single transactions plus
// hand-written starvation, field-stability, spurious-ready and reset sequences.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy, owner;

  sdram_arbiter_if bus();

  sdram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rdata [2];

  typedef struct {
    logic        port;
    logic        write;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dwidth;
    int          lat;        // enable cycles before the controller answers
    logic [31:0] sdata;      // controller read data returned with ready
    logic [31:0] exp_rdata;  // expected pN_rdata of the owner after ack
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.p0_req = 1'b0; bus.p0_addr = '0; bus.p0_write = 1'b0; bus.p0_wdata = '0; bus.p0_dwidth = '0;
    bus.p1_req = 1'b0; bus.p1_addr = '0; bus.p1_write = 1'b0; bus.p1_wdata = '0; bus.p1_dwidth = '0;
    bus.sdram_ready = 1'b0; bus.sdram_rdata = '0;
  endtask

  task automatic drive_port(input logic port, input logic req, input logic write,
                            input logic [24:0] addr, input logic [31:0] wdata, input logic [1:0] dw);
    if (port == PORT_AUX) begin
      bus.p1_req = req; bus.p1_write = write; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_dwidth = dw;
    end else begin
      bus.p0_req = req; bus.p0_write = write; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_dwidth = dw;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic check_rdata(input string tag);
    check({tag, " p0_rdata"}, bus.p0_rdata, exp_rdata[0]);
    check({tag, " p1_rdata"}, bus.p1_rdata, exp_rdata[1]);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive_port(v.port, 1'b1, v.write, v.addr, v.wdata, v.dwidth);
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      check($sformatf("%s enable c%0d", tag, c), 32'(bus.sdram_enable), 32'd1);
      check($sformatf("%s acks c%0d", tag, c), 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
      if (c == 1) begin
        check({tag, " sdram_addr"},   32'(bus.sdram_addr),   32'(v.addr));
        check({tag, " sdram_write"},  32'(bus.sdram_write),  32'(v.write));
        check({tag, " sdram_wdata"},  bus.sdram_wdata,       v.wdata);
        check({tag, " sdram_dwidth"}, 32'(bus.sdram_dwidth), 32'(v.dwidth));
        check({tag, " owner"},        32'(owner),            32'(v.port));
        check({tag, " busy"},         32'(busy),             32'd1);
      end
      if (c == v.lat) begin
        bus.sdram_ready = 1'b1;
        bus.sdram_rdata = v.sdata;
      end
    end
    @(negedge clk);
    bus.sdram_ready = 1'b0;
    bus.sdram_rdata = '0;
    drive_port(v.port, 1'b0, 1'b0, '0, '0, '0);
    exp_rdata[v.port] = v.exp_rdata;
    check({tag, " resp enable"}, 32'(bus.sdram_enable), 32'd0);
    check({tag, " resp acks"}, 32'({bus.p1_ack, bus.p0_ack}), (v.port == PORT_AUX) ? 32'd2 : 32'd1);
    check_rdata({tag, " resp"});
    @(negedge clk);
    check({tag, " idle acks"}, 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle enable"}, 32'(bus.sdram_enable), 32'd0);
  endtask

  logic        st_port  [6];
  logic [3:0]  st_cnt   [6];

  initial begin
    vecs[0] = '{port: PORT_CPU, write: 1'b0, addr: 25'h0000100, wdata: 32'h0,        dwidth: DW_WORD, lat: 3, sdata: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF};
    vecs[1] = '{port: PORT_AUX, write: 1'b1, addr: 25'h1FFFFFC, wdata: 32'h12345678, dwidth: DW_WORD, lat: 2, sdata: 32'h0BADF00D, exp_rdata: 32'h0BADF00D};
    vecs[2] = '{port: PORT_CPU, write: 1'b1, addr: 25'h0000003, wdata: 32'h000000FF, dwidth: DW_BYTE, lat: 1, sdata: 32'h11112222, exp_rdata: 32'h11112222};
    vecs[3] = '{port: PORT_AUX, write: 1'b0, addr: 25'h0ABCDE2, wdata: 32'h0,        dwidth: DW_HALF, lat: 5, sdata: 32'hCAFEF00D, exp_rdata: 32'hCAFEF00D};
    vecs[4] = '{port: PORT_CPU, write: 1'b0, addr: 25'h1FFFFFF, wdata: 32'h0,        dwidth: DW_BYTE, lat: 1, sdata: 32'h80000001, exp_rdata: 32'h80000001};

    st_port = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    st_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst enable", 32'(bus.sdram_enable), 32'd0);
    check("rst busy",   32'(busy), 32'd0);
    check("rst owner",  32'(owner), 32'd0);
    check("rst acks",   32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check("rst p0_rdata", bus.p0_rdata, 32'd0);
    check("rst p1_rdata", bus.p1_rdata, 32'd0);
    check("rst fields", 32'({bus.sdram_write, bus.sdram_dwidth}), 32'd0);
    check("rst addr",   32'(bus.sdram_addr), 32'd0);
    check("rst wdata",  bus.sdram_wdata, 32'd0);
    check("rst starve", 32'(dut.starve_cnt), 32'd0);
    rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Starvation: both ports request continuously
    do_reset();
    @(negedge clk);
    drive_port(PORT_CPU, 1'b1, 1'b0, 25'h0000100, '0, DW_WORD);
    drive_port(PORT_AUX, 1'b1, 1'b0, 25'h0000200, '0, DW_WORD);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      check($sformatf("starve g%0d owner", g), 32'(owner), 32'(st_port[g]));
      check($sformatf("starve g%0d addr", g), 32'(bus.sdram_addr), st_port[g] ? 32'h200 : 32'h100);
      check($sformatf("starve g%0d cnt", g), 32'(dut.starve_cnt), 32'(st_cnt[g]));
      bus.sdram_ready = 1'b1;
      bus.sdram_rdata = 32'h5000 + 32'(g);
      @(negedge clk);
      bus.sdram_ready = 1'b0;
      exp_rdata[st_port[g]] = 32'h5000 + 32'(g);
      check($sformatf("starve g%0d acks", g), 32'({bus.p1_ack, bus.p0_ack}), st_port[g] ? 32'd2 : 32'd1);
      check_rdata($sformatf("starve g%0d", g));
      if (g == 5) begin
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
      end
      @(negedge clk);
      check($sformatf("starve g%0d idle busy", g), 32'(busy), 32'd0);
    end

    // Field stability: requester changes fields during BUSY
    @(negedge clk);
    drive_port(PORT_CPU, 1'b1, 1'b0, 25'h0000100, '0, DW_WORD);
    @(negedge clk);
    check("stab busy1 addr", 32'(bus.sdram_addr), 32'h100);
    drive_port(PORT_CPU, 1'b1, 1'b1, 25'h0000200, 32'hFFFF0000, DW_HALF);
    @(negedge clk);
    check("stab busy2 addr",  32'(bus.sdram_addr), 32'h100);
    check("stab busy2 write", 32'(bus.sdram_write), 32'd0);
    check("stab busy2 wdata", bus.sdram_wdata, 32'd0);
    @(negedge clk);
    check("stab busy3 addr", 32'(bus.sdram_addr), 32'h100);
    bus.sdram_ready = 1'b1;
    bus.sdram_rdata = 32'h0000ABCD;
    @(negedge clk);
    bus.sdram_ready = 1'b0;
    drive_port(PORT_CPU, 1'b0, 1'b0, '0, '0, '0);
    exp_rdata[0] = 32'h0000ABCD;
    check("stab resp addr", 32'(bus.sdram_addr), 32'h100);
    check("stab resp ack0", 32'(bus.p0_ack), 32'd1);
    @(negedge clk);

    // Spurious ready in IDLE
    bus.sdram_ready = 1'b1;
    bus.sdram_rdata = 32'h55555555;
    @(negedge clk);
    bus.sdram_ready = 1'b0;
    check("spur idle acks", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check("spur idle busy", 32'(busy), 32'd0);
    check("spur idle enable", 32'(bus.sdram_enable), 32'd0);
    check_rdata("spur idle");

    // Spurious ready in RESP
    drive_port(PORT_AUX, 1'b1, 1'b0, 25'h0000040, '0, DW_WORD);
    @(negedge clk);
    bus.sdram_ready = 1'b1;
    bus.sdram_rdata = 32'h600DCAFE;
    @(negedge clk);
    exp_rdata[1] = 32'h600DCAFE;
    check("spur resp ack1", 32'(bus.p1_ack), 32'd1);
    bus.sdram_ready = 1'b1;
    bus.sdram_rdata = 32'hBAD0BAD0;
    drive_port(PORT_AUX, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    bus.sdram_ready = 1'b0;
    bus.sdram_rdata = '0;
    check("spur after resp acks", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check("spur after resp busy", 32'(busy), 32'd0);
    check_rdata("spur after resp");
    @(negedge clk);
    check("spur later acks", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);

    // Reset two cycles into BUSY
    drive_port(PORT_CPU, 1'b1, 1'b0, 25'h0000300, '0, DW_WORD);
    drive_port(PORT_AUX, 1'b1, 1'b0, 25'h0000400, '0, DW_WORD);
    @(negedge clk);
    check("rstbusy owner", 32'(owner), 32'd0);
    check("rstbusy starve", 32'(dut.starve_cnt), 32'd1);
    @(negedge clk);
    check("rstbusy enable2", 32'(bus.sdram_enable), 32'd1);
    rst = 1'b1;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(negedge clk);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    check("rstbusy after enable", 32'(bus.sdram_enable), 32'd0);
    check("rstbusy after busy",   32'(busy), 32'd0);
    check("rstbusy after acks",   32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check("rstbusy after starve", 32'(dut.starve_cnt), 32'd0);
    check_rdata("rstbusy after");
    rst = 1'b0;
    @(negedge clk);
    check("rstbusy idle acks", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
    check("rstbusy idle enable", 32'(bus.sdram_enable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
